pipe_stage_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_stage_reg.sv | 46 ++++
 rtl/pipe_stage_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared constants and types for the pipeline stage control block.
//   STAGES_DEF / DATA_W_DEF : default stage count and payload width
//   CNT_W_DEF               : default performance counter width
//   stage_idx_t             : index type covering the legal 2..8 stages
//   DBG_NIB_W / DBG_W       : valid_dbg nibble width and total width
package pipe_pkg;
    localparam int STAGES_DEF = 5;
    localparam int DATA_W_DEF = 171;
    localparam int CNT_W_DEF  = 32;
    localparam int DBG_NIB_W  = 4;
    localparam int DBG_W      = 32;

    typedef logic [2:0] stage_idx_t;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// One pipeline stage: its valid bit and its payload register.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   i_flush         : kill this stage's content; payload is held
//   i_allow_in      : stage may take a new valid/payload this cycle
//   i_inc           : upstream offers a payload this cycle
//   i_bus           : payload offered by upstream
//   o_valid, o_bus  : registered valid and payload
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_allow_in,
    input  logic              i_inc,
    input  logic [DATA_W-1:0] i_bus,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_bus
);

    logic              r_valid;
    logic [DATA_W-1:0] r_bus;

    // Flush wins over acceptance, so an incoming payload in a flushed cycle is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_allow_in) begin
            r_valid <= i_inc;
            if (i_inc) begin
                r_bus <= i_bus;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_bus   = r_bus;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl
// N-stage pipeline handshake control plus the inter-stage payload registers.
// Optional performance counters are built when PIPE_PERF_EN is defined.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   in_valid/in_ready : source handshake into stage 0
//   stage_bus_in      : slot k is the payload latched into stage k
//   stage_over        : stage k finished its work this cycle
//   flush             : kill stage k's content this cycle
//   out_ready         : consumer after the last stage accepts
//   stage_valid       : registered valid per stage
//   stage_allow_in    : per-stage allow_in
//   stage_bus_r       : registered payload per stage
//   out_valid         : last stage hands off this cycle
//   valid_dbg         : {4{valid[k]}} per stage, stage 0 in the top used nibble
//   perf_retired/perf_stall/perf_flushed : counters (PIPE_PERF_EN only)
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [STAGES*DATA_W-1:0] stage_bus_in,
    input  logic [STAGES-1:0]        stage_over,
    input  logic [STAGES-1:0]        flush,
    input  logic                     out_ready,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES-1:0]        stage_allow_in,
    output logic [STAGES*DATA_W-1:0] stage_bus_r,
    output logic                     out_valid,
    output logic [DBG_W-1:0]         valid_dbg
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]         perf_retired,
    output logic [CNT_W-1:0]         perf_stall,
    output logic [CNT_W-1:0]         perf_flushed
`endif
);

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $error("pipe_stage_ctrl: STAGES must be in 2..8");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_ctrl: CNT_W must be positive");
    end

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_fwd;
    logic [STAGES-1:0] w_inc;
    logic [STAGES-1:0] w_allow;

    assign w_fwd = w_valid & stage_over & ~flush;
    assign w_inc = {w_fwd[STAGES-2:0], in_valid & ~flush[0]};

    // Ready ripples from the consumer back towards stage 0. A flushed stage
    // always accepts so it never blocks the stage above it.
    always_comb begin : p_allow
        logic w_down;
        w_down  = out_ready;
        w_allow = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_down     = ~w_valid[k] | flush[k] | (stage_over[k] & w_down);
            w_allow[k] = w_down;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_stage_reg #(
            .DATA_W (DATA_W)
        ) u_stage_reg (
            .clk        (clk),
            .reset      (reset),
            .i_flush    (flush[k]),
            .i_allow_in (w_allow[k]),
            .i_inc      (w_inc[k]),
            .i_bus      (stage_bus_in[k*DATA_W +: DATA_W]),
            .o_valid    (w_valid[k]),
            .o_bus      (stage_bus_r[k*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        valid_dbg = '0;
        for (int k = 0; k < STAGES; k++) begin
            valid_dbg[(STAGES-1-k)*DBG_NIB_W +: DBG_NIB_W] = {DBG_NIB_W{w_valid[k]}};
        end
    end

    assign in_ready       = w_allow[0];
    assign out_valid      = w_fwd[STAGES-1];
    assign stage_valid    = w_valid;
    assign stage_allow_in = w_allow;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flushed;
    logic [CNT_W-1:0] w_flush_cnt;

    // Number of live stages discarded this cycle.
    always_comb begin
        w_flush_cnt = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_flush_cnt = w_flush_cnt + CNT_W'(w_valid[k] & flush[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
            r_stall   <= '0;
            r_flushed <= '0;
        end else begin
            if (out_valid & out_ready) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (in_valid & ~in_ready & ~flush[0]) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            r_flushed <= r_flushed + w_flush_cnt;
        end
    end

    assign perf_retired = r_retired;
    assign perf_stall   = r_stall;
    assign perf_flushed = r_flushed;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
module tb_pipe_stage_ctrl;
    localparam int STAGES = 5;
    localparam int DATA_W = 171;
    localparam int CNT_W  = 32;

    typedef logic [DATA_W-1:0] bus_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [STAGES*DATA_W-1:0] stage_bus_in;
    logic [STAGES-1:0]        stage_over = '0;
    logic [STAGES-1:0]        flush = '0;
    logic                     out_ready = 1'b0;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES-1:0]        stage_allow_in;
    logic [STAGES*DATA_W-1:0] stage_bus_r;
    logic                     out_valid;
    logic [31:0]              valid_dbg;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0]         perf_retired;
    logic [CNT_W-1:0]         perf_stall;
    logic [CNT_W-1:0]         perf_flushed;
`endif

    bus_t r_fetch = '0;
    bus_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    pipe_stage_ctrl #(
        .STAGES (STAGES),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .stage_bus_in   (stage_bus_in),
        .stage_over     (stage_over),
        .flush          (flush),
        .out_ready      (out_ready),
        .stage_valid    (stage_valid),
        .stage_allow_in (stage_allow_in),
        .stage_bus_r    (stage_bus_r),
        .out_valid      (out_valid),
        .valid_dbg      (valid_dbg)
`ifdef PIPE_PERF_EN
        ,
        .perf_retired   (perf_retired),
        .perf_stall     (perf_stall),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    // Each stage's combinational work is modelled as "+1", so a payload p
    // leaves the last stage as p + (STAGES-1).
    always_comb begin
        stage_bus_in = '0;
        stage_bus_in[DATA_W-1:0] = r_fetch;
        for (int k = 1; k < STAGES; k++) begin
            stage_bus_in[k*DATA_W +: DATA_W] = stage_bus_r[(k-1)*DATA_W +: DATA_W] + bus_t'(1);
        end
    end

    function automatic bus_t slot(input int k);
        return stage_bus_r[k*DATA_W +: DATA_W];
    endfunction

    task automatic chk(input string name, input bus_t act, input bus_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic iv, input bus_t p, input logic [STAGES-1:0] ov,
                       input logic [STAGES-1:0] fl, input logic ordy);
        in_valid   = iv;
        r_fetch    = p;
        stage_over = ov;
        flush      = fl;
        out_ready  = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handoff from the last stage pops one expectation.
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard_extra: got %0h, expected no handoff", slot(STAGES-1));
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard", slot(STAGES-1), e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    bus_t'(stage_valid),    bus_t'(0));
        chk("rst_in_ready", bus_t'(in_ready),       bus_t'(1));
        chk("rst_out_val",  bus_t'(out_valid),      bus_t'(0));
        chk("rst_allow",    bus_t'(stage_allow_in), bus_t'(5'b11111));
        chk("rst_dbg",      bus_t'(valid_dbg),      bus_t'(0));
        chk("rst_bus4",     slot(4),                bus_t'(0));
        @(negedge clk);
        reset = 1'b0;
        #2;

        // 1: continuous stream, latency and full throughput
        for (int n = 1; n <= 12; n++) begin
            drv(1'b1, bus_t'(n), '1, '0, 1'b1);
            exp_q.push_back(bus_t'(n + 4));
            if (n == 5) chk("t1_not_yet", bus_t'(out_valid), bus_t'(0));
            if (n == 6) chk("t1_latency", slot(4), bus_t'(5));
            if (n >= 6) chk("t1_out_valid", bus_t'(out_valid), bus_t'(1));
            tick();
        end

        // 2: stage 2 not over for three cycles
        for (int c = 0; c < 3; c++) begin
            drv(1'b1, bus_t'(13), 5'b11011, '0, 1'b1);
            if (c == 0) exp_q.push_back(bus_t'(17));
            chk("t2_in_ready", bus_t'(in_ready), bus_t'(0));
            chk("t2_allow", bus_t'(stage_allow_in), bus_t'(5'b11000));
            if (c == 2) begin
                chk("t2_valid", bus_t'(stage_valid), bus_t'(5'b00111));
                for (int k = 0; k < 3; k++) chk("t2_hold", slot(k), bus_t'(12));
            end
            tick();
        end
        drv(1'b1, bus_t'(13), '1, '0, 1'b1);
        chk("t2_resume", bus_t'(in_ready), bus_t'(1));
        tick();
        for (int n = 14; n <= 19; n++) begin
            drv(1'b1, bus_t'(n), '1, '0, 1'b1);
            exp_q.push_back(bus_t'(n + 4));
            tick();
        end

        // 3: flush everything in a full pipe
        chk("t3_full", bus_t'(stage_valid), bus_t'(5'b11111));
        drv(1'b1, bus_t'(20), '1, 5'b11111, 1'b1);
        exp_q.delete();
        tick();
        chk("t3_flushed", bus_t'(stage_valid), bus_t'(0));
`ifdef PIPE_PERF_EN
        chk("t3_perf_flushed", bus_t'(perf_flushed), bus_t'(5));
`endif

        // 4: flush[0] with an incoming payload
        drv(1'b1, bus_t'(8'hAA), '1, 5'b00001, 1'b1);
        tick();
        chk("t4_valid", bus_t'(stage_valid), bus_t'(0));
        chk("t4_bus_held", slot(0), bus_t'(19));

        // 5: consumer stalls a full pipe
        for (int n = 0; n < 5; n++) begin
            drv(1'b1, bus_t'(32'h100 + n), '1, '0, 1'b1);
            exp_q.push_back(bus_t'(32'h104 + n));
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drv(1'b1, bus_t'(32'h105), '1, '0, 1'b0);
            if (c == 0) exp_q.push_back(bus_t'(32'h109));
            chk("t5_in_ready", bus_t'(in_ready), bus_t'(0));
            chk("t5_allow", bus_t'(stage_allow_in), bus_t'(0));
            chk("t5_valid", bus_t'(stage_valid), bus_t'(5'b11111));
            for (int k = 0; k < STAGES; k++) chk("t5_hold", slot(k), bus_t'(32'h104));
            tick();
        end
        drv(1'b1, bus_t'(32'h105), '1, '0, 1'b1);
        tick();
        for (int n = 6; n <= 8; n++) begin
            drv(1'b1, bus_t'(32'h100 + n), '1, '0, 1'b1);
            exp_q.push_back(bus_t'(32'h104 + n));
            tick();
        end

        // 6: asynchronous reset between edges with a full pipe
        drv(1'b0, bus_t'(0), '1, '0, 1'b1);
        chk("t6_dbg_full", bus_t'(valid_dbg), bus_t'(32'h000F_FFFF));
`ifdef PIPE_PERF_EN
        chk("t6_perf_retired", bus_t'(perf_retired), bus_t'(18));
        chk("t6_perf_stall",   bus_t'(perf_stall),   bus_t'(6));
        chk("t6_perf_flushed", bus_t'(perf_flushed), bus_t'(5));
`endif
        reset = 1'b1;
        #1;
        chk("t6_valid", bus_t'(stage_valid), bus_t'(0));
        chk("t6_dbg",   bus_t'(valid_dbg),   bus_t'(0));
        chk("t6_ready", bus_t'(in_ready),    bus_t'(1));
        chk("t6_out",   bus_t'(out_valid),   bus_t'(0));
        chk("t6_bus4",  slot(4),             bus_t'(0));
`ifdef PIPE_PERF_EN
        chk("t6_perf_clr", bus_t'(perf_retired), bus_t'(0));
`endif
        exp_q.delete();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        drv(1'b1, bus_t'(32'h200), '1, '0, 1'b1);
        exp_q.push_back(bus_t'(32'h204));
        tick();
        chk("t6_first_valid", bus_t'(stage_valid), bus_t'(5'b00001));
        chk("t6_first_bus",   slot(0),             bus_t'(32'h200));
        drv(1'b0, bus_t'(0), '1, '0, 1'b1);
        repeat (6) tick();
        chk("drain_empty", bus_t'(exp_q.size()), bus_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
